// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register,
// honours load-use stalls and EX branch redirects, and counts stall/flush events.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               IF_ID_write,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc4,
    output logic [31:0]        if_id_instr,
    output logic               if_id_valid,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_if_id_pc;
    logic [31:0]        r_if_id_pc4;
    logic [31:0]        r_if_id_instr;
    logic               r_if_id_valid;
    logic [COUNT_W-1:0] r_stall_count;
    logic [COUNT_W-1:0] r_flush_count;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_target_aligned;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_target_aligned = {branch_target[31:2], 2'b00};

    // PC, IF/ID register, counters and BOOT/RUN sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_pc4   <= 32'h0000_0004;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_stall_count <= {COUNT_W{1'b0}};
            r_flush_count <= {COUNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                    if (branch_taken) begin
                        // Redirect wins over any stall; the held ID instruction is wrong-path
                        r_pc          <= w_target_aligned;
                        r_if_id_pc    <= r_pc;
                        r_if_id_pc4   <= w_pc_plus4;
                        r_if_id_instr <= NOP_INSTR;
                        r_if_id_valid <= 1'b0;
                        r_flush_count <= sat_inc(r_flush_count);
                    end else begin
                        if (pc_write) begin
                            r_pc <= w_pc_plus4;
                        end else begin
                            r_pc <= r_pc;
                        end
                        if (IF_ID_write) begin
                            r_if_id_pc    <= r_pc;
                            r_if_id_pc4   <= w_pc_plus4;
                            r_if_id_instr <= imem_rdata;
                            r_if_id_valid <= 1'b1;
                        end else begin
                            r_stall_count <= sat_inc(r_stall_count);
                        end
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, stalls, branches,
// PC wrap, counter saturation and mid-run reset.
module tb_fetch_unit;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          pc_write;
    logic          IF_ID_write;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   if_id_pc;
    logic [31:0]   if_id_pc4;
    logic [31:0]   if_id_instr;
    logic          if_id_valid;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(32'h0000_0013),
        .COUNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_write     (pc_write),
        .IF_ID_write  (IF_ID_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: three known words, everything else address-derived
    always_comb begin
        case (imem_addr)
            32'h0000_0100: imem_rdata = 32'h0000_000A;
            32'h0000_0104: imem_rdata = 32'h0000_000B;
            32'h0000_0108: imem_rdata = 32'h0000_000C;
            default:       imem_rdata = imem_addr ^ 32'hDEAD_0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".addr"},  imem_addr,   32'h0000_0100);
        check({tag, ".pc"},    if_id_pc,    32'h0000_0000);
        check({tag, ".pc4"},   if_id_pc4,   32'h0000_0004);
        check({tag, ".instr"}, if_id_instr, 32'h0000_0013);
        check({tag, ".valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, ".stall"}, {28'd0, stall_count}, 32'd0);
        check({tag, ".flush"}, {28'd0, flush_count}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        pc_write      = 1'b1;
        IF_ID_write   = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_3000;
        #12;
        check_reset_state("reset");

        // BOOT edge: branch and stall request must both be ignored
        rst_n = 1'b1;
        step();
        check("boot.addr",  imem_addr, 32'h0000_0100);
        check("boot.valid", {31'd0, if_id_valid}, 32'd0);
        check("boot.flush", {28'd0, flush_count}, 32'd0);
        check("boot.stall", {28'd0, stall_count}, 32'd0);

        branch_taken = 1'b0;
        IF_ID_write  = 1'b1;
        step();
        check("fetch1.pc",    if_id_pc,    32'h0000_0100);
        check("fetch1.pc4",   if_id_pc4,   32'h0000_0104);
        check("fetch1.instr", if_id_instr, 32'h0000_000A);
        check("fetch1.valid", {31'd0, if_id_valid}, 32'd1);
        check("fetch1.addr",  imem_addr,   32'h0000_0104);
        step();
        check("fetch2.instr", if_id_instr, 32'h0000_000B);
        check("fetch2.pc4",   if_id_pc4,   32'h0000_0108);
        check("fetch2.addr",  imem_addr,   32'h0000_0108);

        // Load-use stall for two cycles
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        step();
        step();
        check("stall.addr",  imem_addr,   32'h0000_0108);
        check("stall.pc",    if_id_pc,    32'h0000_0104);
        check("stall.instr", if_id_instr, 32'h0000_000B);
        check("stall.count", {28'd0, stall_count}, 32'd2);

        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        step();
        check("resume.instr", if_id_instr, 32'h0000_000C);
        check("resume.pc",    if_id_pc,    32'h0000_0108);
        check("resume.addr",  imem_addr,   32'h0000_010C);

        // Branch while stalled, misaligned target
        pc_write      = 1'b0;
        IF_ID_write   = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_2002;
        step();
        check("br.addr",  imem_addr,   32'h0000_2000);
        check("br.instr", if_id_instr, 32'h0000_0013);
        check("br.valid", {31'd0, if_id_valid}, 32'd0);
        check("br.pc",    if_id_pc,    32'h0000_010C);
        check("br.pc4",   if_id_pc4,   32'h0000_0110);
        check("br.flush", {28'd0, flush_count}, 32'd1);
        check("br.stall", {28'd0, stall_count}, 32'd2);

        // Mismatched controls: PC advances, IF/ID holds
        branch_taken = 1'b0;
        pc_write     = 1'b1;
        IF_ID_write  = 1'b0;
        step();
        check("mis1.addr",  imem_addr, 32'h0000_2004);
        check("mis1.pc",    if_id_pc,  32'h0000_010C);
        check("mis1.stall", {28'd0, stall_count}, 32'd3);

        // Opposite mismatch: PC holds, IF/ID loads
        pc_write    = 1'b0;
        IF_ID_write = 1'b1;
        step();
        check("mis2.addr",  imem_addr,   32'h0000_2004);
        check("mis2.pc",    if_id_pc,    32'h0000_2004);
        check("mis2.instr", if_id_instr, 32'hDEAD_2004);
        check("mis2.valid", {31'd0, if_id_valid}, 32'd1);

        // PC wrap at the top of the address space
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        check("wrapbr.addr",  imem_addr, 32'hFFFF_FFFC);
        check("wrapbr.flush", {28'd0, flush_count}, 32'd2);
        branch_taken = 1'b0;
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        step();
        check("wrap.addr",  imem_addr,   32'h0000_0000);
        check("wrap.pc",    if_id_pc,    32'hFFFF_FFFC);
        check("wrap.pc4",   if_id_pc4,   32'h0000_0000);
        check("wrap.instr", if_id_instr, 32'h2152_FFFC);

        // Stall counter saturation (starts at 3, 20 more stalls)
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat.stall", {28'd0, stall_count}, 32'd15);
        check("sat.addr",  imem_addr, 32'h0000_0000);

        // Mid-cycle reset takes effect before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        #2;
        rst_n       = 1'b1;
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        step();
        check("reboot.addr",  imem_addr, 32'h0000_0100);
        check("reboot.valid", {31'd0, if_id_valid}, 32'd0);
        step();
        check("rerun.instr", if_id_instr, 32'h0000_000A);
        check("rerun.valid", {31'd0, if_id_valid}, 32'd1);
        check("rerun.addr",  imem_addr,   32'h0000_0104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register. It consumes the load-use stall controls (pc_write, IF_ID_write) produced by the hazard detection unit, plus branch redirects from EX. It owns the PC, drives the instruction-memory address, and presents the fetched instruction to ID. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction inserted on flush (addi x0,x0,0).
COUNT_W, 16, width of the stall and flush counters.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
pc_write  input  1  1 = PC may update; 0 = hold PC (load-use stall).
IF_ID_write  input  1  1 = IF/ID may load; 0 = hold IF/ID contents.
branch_taken  input  1  redirect request from EX, valid this cycle.
branch_target  input  32  redirect address.
imem_addr  output  32  instruction address; equals the PC (combinational from the PC register).
imem_rdata  input  32  instruction at imem_addr, asynchronous read, same cycle.
if_id_pc  output  32  PC of the instruction held in IF/ID.
if_id_pc4  output  32  if_id_pc + 4.
if_id_instr  output  32  instruction held in IF/ID.
if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
stall_count  output  COUNT_W  cycles with IF_ID_write=0 in RUN.
flush_count  output  COUNT_W  accepted branch redirects.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on rst_n.
- While rst_n=0 and at its assertion:
  - pc=RESET_PC, if_id_pc=0, if_id_pc4=4, if_id_instr=NOP_INSTR, if_id_valid=0.
  - stall_count=0, flush_count=0, state=BOOT.
- Reset mid-operation: all of the above applies immediately. No partial update of any register.
- State machine, two states:
  - BOOT: the first rising edge after rst_n deasserts. PC holds and IF/ID holds the bubble. All inputs are ignored, counters included. Next state is RUN.
  - RUN: stays in RUN until reset.
- RUN update on each rising edge, first matching rule wins:
  1. branch_taken=1: pc <= {branch_target[31:2],2'b00}. IF/ID <= {pc, pc+4, NOP_INSTR, valid=0}. flush_count increments.
     - Overrides pc_write=0 and IF_ID_write=0. The stalled ID instruction is wrong-path.
     - stall_count does not increment this cycle.
  2. Otherwise, PC update: pc <= pc+4 if pc_write=1, else pc holds.
  3. Otherwise, IF/ID update: if IF_ID_write=1, IF/ID <= {pc, pc+4, imem_rdata, valid=1}. Else IF/ID holds all fields and stall_count increments.
  - pc_write and IF_ID_write act independently. A mismatched pair (e.g. pc_write=1, IF_ID_write=0) is legal and follows rules 2 and 3 literally.
- Fetch-to-ID latency: one cycle. The instruction at pc appears on if_id_instr the cycle after the edge on which IF/ID loads.
- Arithmetic:
  - pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. if_id_pc4 wraps the same way.
  - branch_target bits [1:0] are ignored and forced to 0. No error is flagged.
- Counters saturate at all-ones and never wrap.
- Simultaneous events: a branch on the first RUN cycle is honoured. A branch during BOOT is dropped.
- imem_addr changes only on clock edges or reset, never glitches from input changes.

Test Plan:
- Reset release: rst_n low, then high with RESET_PC=32'h100 -> imem_addr=0x100 through BOOT. Next edge: if_id_pc=0x100, valid=1, imem_addr=0x104.
- Sequential fetch: imem returns 0xA,0xB,0xC at 0x100/0x104/0x108 -> if_id_instr is 0xA,0xB,0xC on consecutive cycles, with if_id_pc4 = if_id_pc+4.
- Load-use stall: pc_write=0 and IF_ID_write=0 for 2 cycles at pc=0x108 -> pc stays 0x108 and IF/ID is unchanged. stall_count=2. Normal flow resumes on release.
- Branch during stall: pc_write=0, IF_ID_write=0, branch_taken=1, target=0x2002 -> pc=0x2000, if_id_instr=0x13, valid=0. flush_count=1, stall_count unchanged.
- Wrap: pc=0xFFFF_FFFC with normal flow -> pc=0, if_id_pc=0xFFFF_FFFC, if_id_pc4=0.
- Saturation and mid-run reset: COUNT_W=4, 20 stall cycles -> stall_count=15. Then rst_n pulses low mid-cycle -> all outputs return to reset values at once, before the next edge.
